// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave in front of a word-organised single-port SRAM.
// Supports wait states, byte lanes, two-cycle ERROR and write-to-read forwarding.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   hsel            slave select from the interconnect
//   haddr           byte address; bits [log2(MEM_DEPTH)+1:2] index the word
//   htrans          00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//   hwrite, hsize   direction and size (byte/half/word)
//   hwdata          write data, valid in the data phase
//   hrdata          read data, zero outside a read completion cycle
//   hready, hresp   transfer done / ERROR response
module ahb_sram_slave #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int MEM_DEPTH   = 1024,
   parameter int WAIT_STATES = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  hsel,
   input  logic [ADDR_WIDTH-1:0] haddr,
   input  logic [1:0]            htrans,
   input  logic                  hwrite,
   input  logic [2:0]            hsize,
   input  logic [DATA_WIDTH-1:0] hwdata,
   output logic [DATA_WIDTH-1:0] hrdata,
   output logic                  hready,
   output logic                  hresp
);

   localparam int IW = $clog2(MEM_DEPTH);
   localparam int NL = 4;
   localparam logic [2:0] WS = 3'(WAIT_STATES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_ERR1,
      S_ERR2
   } state_t;

   state_t                state;
   logic [2:0]            cnt;
   logic [IW-1:0]         idx_q;
   logic                  wr_q;
   logic [NL-1:0]         mask_q;
   logic [DATA_WIDTH-1:0] rd_q;

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   logic                  accept;
   logic                  legal;
   logic                  commit;
   logic [IW-1:0]         idx_d;
   logic [NL-1:0]         mask_d;
   logic [DATA_WIDTH-1:0] fwd;

   logic unused;
   assign unused = ^{haddr[ADDR_WIDTH-1:IW+2], htrans[0]};

   always_comb begin
      accept = hsel && htrans[1] && hready;
      idx_d  = haddr[IW+1:2];
      legal  = 1'b0;
      mask_d = '0;
      unique case (hsize)
         3'b000: begin
            legal  = 1'b1;
            mask_d = 4'b0001 << haddr[1:0];
         end
         3'b001: begin
            legal  = !haddr[0];
            mask_d = haddr[1] ? 4'b1100 : 4'b0011;
         end
         3'b010: begin
            legal  = (haddr[1:0] == 2'b00);
            mask_d = 4'b1111;
         end
         default: begin
            legal  = 1'b0;
            mask_d = '0;
         end
      endcase
   end

   // Write lands on the completion-cycle edge.
   assign commit = (state == S_DATA) && (cnt == 3'd0) && wr_q;

   // A read accepted on the same edge as a committing write to the
   // same word sees the merged word rather than the old array value.
   always_comb begin
      fwd = mem[idx_d];
      if (commit && (idx_q == idx_d)) begin
         for (int i = 0; i < NL; i++) begin
            if (mask_q[i]) fwd[8*i +: 8] = hwdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (commit && !rst) begin
         for (int i = 0; i < NL; i++) begin
            if (mask_q[i]) mem[idx_q][8*i +: 8] <= hwdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         cnt    <= 3'd0;
         idx_q  <= '0;
         wr_q   <= 1'b0;
         mask_q <= '0;
         rd_q   <= '0;
         hready <= 1'b1;
         hresp  <= 1'b0;
         hrdata <= '0;
      end else begin
         hrdata <= '0;
         if (state == S_ERR1) begin
            state  <= S_ERR2;
            hready <= 1'b1;
            hresp  <= 1'b1;
         end else if ((state == S_DATA) && (cnt != 3'd0)) begin
            cnt    <= cnt - 3'd1;
            hready <= (cnt == 3'd1);
            if ((cnt == 3'd1) && !wr_q) hrdata <= rd_q;
         end else if (accept && legal) begin
            state  <= S_DATA;
            cnt    <= WS;
            idx_q  <= idx_d;
            wr_q   <= hwrite;
            mask_q <= mask_d;
            rd_q   <= fwd;
            hready <= (WS == 3'd0);
            hresp  <= 1'b0;
            if ((WS == 3'd0) && !hwrite) hrdata <= fwd;
         end else if (accept) begin
            state  <= S_ERR1;
            hready <= 1'b0;
            hresp  <= 1'b1;
         end else begin
            state  <= S_IDLE;
            hready <= 1'b1;
            hresp  <= 1'b0;
         end
      end
   end

endmodule

// File: doc/ahb_sram_slave.md
# ahb_sram_slave

AHB-Lite responder wrapping a single-port word-organised on-chip SRAM. It is the slave-side counterpart of the AHB interconnect and sits on the SRAM slot, slot 1 at 0x2000_0000. It consumes one slave port's hsel and the shared address/control/write-data bus, and returns hrdata/hready/hresp. Configurable wait states, byte-lane writes, two-cycle ERROR responses, and read-after-write forwarding for back-to-back transfers are included.

## Interface
- ADDR_WIDTH, 32, address bus width
- DATA_WIDTH, 32, data bus width; only 32 is supported
- MEM_DEPTH, 1024, number of 32-bit words; must be a power of two
- WAIT_STATES, 0, wait cycles inserted per OKAY data phase, 0..7
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous reset, active-high
- hsel  in  1  slave select from interconnect
- haddr  in  ADDR_WIDTH  byte address; bits [log2(MEM_DEPTH)+1:2] index the word, upper bits are ignored
- htrans  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- hwrite  in  1  1 = write
- hsize  in  3  000 byte, 001 half, 010 word; any other value is illegal
- hwdata  in  DATA_WIDTH  write data, valid in the data phase
- hrdata  out  DATA_WIDTH  read data
- hready  out  1  transfer-done / ready-for-address
- hresp  out  1  0 OKAY, 1 ERROR

## Operation
- **Accept rule:** an address phase is accepted at a rising edge where hsel=1, htrans[1]=1 and hready=1. At acceptance, capture the address, hwrite, hsize and the byte-lane mask.
- **Illegal transfers go to ERROR with no memory access:** hsize>010; half-word with addr[0]=1; word with addr[1:0]≠00.
- **IDLE/BUSY with hsel=1, or hsel=0:** no transfer. The block gives a zero-wait OKAY response.
- **FSM states:**
  - IDLE: hready=1, hresp=0.
  - DATA: a data phase is pending; a 3-bit wait counter is loaded with WAIT_STATES on acceptance.
  - ERR1: hready=0, hresp=1.
  - ERR2: hready=1, hresp=1.
- **Transitions:**
  - From IDLE, DATA (final cycle) or ERR2: a legal accept goes to DATA, an illegal accept goes to ERR1, otherwise go to IDLE.
  - In DATA with counter>0: hready=0, counter decrements each cycle, no new accept.
  - In DATA with counter=0: hready=1 (the completion cycle).
  - ERR1 always goes to ERR2.
- **Write commit:** at the completion-cycle edge, write hwdata into the captured word under the lane mask. Lanes are little-endian:
  - byte: lane addr[1:0]
  - half: lanes {addr[1],0} and {addr[1],1}
  - word: all four lanes
- **Read:** returns the full 32-bit word regardless of hsize. hrdata is the registered word while in a read DATA completion cycle, and 0 in every other cycle.
- **Forwarding:** when a read is accepted on the same edge a write to the same word commits, the read returns the merged word, i.e. new bytes in the written lanes and old bytes elsewhere. There is no stale data.
- **Reset:** aborts any pending transfer. A pending write is discarded. SRAM contents are not cleared.

## Timing
- **Reset values:** hready=1, hresp=0, hrdata=0, state IDLE, counter 0.
- **OKAY latency:** data phase lasts WAIT_STATES+1 cycles after the accept edge, with hready low for the first WAIT_STATES cycles.
- **Throughput:** with WAIT_STATES=0, back-to-back NONSEQ/SEQ transfers complete one per cycle. The next address is accepted in the current completion cycle.
- **ERROR:** exactly 2 cycles (hready=0 then hready=1), with hresp=1 in both. The next address is only accepted in the second cycle.
- **Read data source:** SRAM read is issued at the accept edge. Read data must not depend combinationally on haddr.
- **Address phase during wait states:** inputs are ignored while hready=0. The interconnect holds the address phase stable.

## Test plan
- **Word write/read:** write 0xDEADBEEF to 0x2000_0010, then read 0x2000_0010 → hrdata=0xDEADBEEF. With WAIT_STATES=0 each transfer has a 1-cycle data phase and hresp=0.
- **Byte/half lanes:** word 0x11223344 at 0x20, then byte write 0xAA to 0x21, then half write 0xBBCC to 0x22; read 0x20 → 0xBBCCAA44.
- **Back-to-back RAW:** write 0x12345678 to 0x40 immediately followed by a read of 0x40, pipelined and with no idle cycle → read returns 0x12345678. A subsequent byte write of 0xFF to 0x40 followed by a read → 0x123456FF.
- **Wait states:** WAIT_STATES=3; a read of 0x40 shows hready low for exactly 3 cycles, then high with data. A write is likewise 3+1 cycles.
- **ERROR:** word read at 0x2000_0002, then a word read at 0x2000_0000 issued during ERR2 → hready 0/1, hresp 1/1, followed by a normal OKAY read. A word write at an address with addr[1:0]≠00 → ERROR and memory unchanged on readback. hsize=011 → ERROR.
- **Reset mid-transfer / idle:** assert rst during a write's wait state → hready=1, hresp=0, hrdata=0 next cycle, and the target word is unchanged. hsel=1 with htrans=IDLE/BUSY → hready stays 1 and no access occurs.
